// File: rtl/mem_axil_master.sv
// -----------------------------------------------------------------------------
// mem_axil_master
//
// Bridges a CPU-side simple memory request port (valid/ready, one word, byte
// strobes) onto an AXI-Lite master port. It handles one transaction at a time.
// A write runs AW and W in parallel and then collects B. A read runs AR and
// then collects R. Every transaction ends with a one-cycle mem_ready pulse that
// carries the read data and the error flag.
//
// Ports
//   clk_i, rst_i            clock; synchronous active-high reset
//   mem_valid/mem_ready     CPU request and one-cycle completion pulse
//   mem_addr/wdata/wstrb    request payload (wstrb == 0 means read)
//   mem_rdata/mem_err       read data and non-OKAY response flag
//   m_axil_aw*/w*/b*        AXI-Lite write address, data and response channels
//   m_axil_ar*/r*           AXI-Lite read address and data channels
// -----------------------------------------------------------------------------
module mem_axil_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // CPU side
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [STRB_WIDTH-1:0] mem_wstrb,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_err,
  // AXI-Lite write address
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  // AXI-Lite write data
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  // AXI-Lite write response
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  // AXI-Lite read address
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  // AXI-Lite read data
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_WR_B, ST_RD_A, ST_RD_R, ST_DONE
  } state_t;

  state_t                r_state,     w_state_nx;
  logic                  r_awvalid,   w_awvalid_nx;
  logic                  r_wvalid,    w_wvalid_nx;
  logic                  r_bready,    w_bready_nx;
  logic                  r_arvalid,   w_arvalid_nx;
  logic                  r_rready,    w_rready_nx;
  logic                  r_aw_done,   w_aw_done_nx;
  logic                  r_w_done,    w_w_done_nx;
  logic                  r_mem_ready, w_mem_ready_nx;
  logic                  r_mem_err,   w_mem_err_nx;
  logic [DATA_WIDTH-1:0] r_rdata,     w_rdata_nx;
  logic [ADDR_WIDTH-1:0] r_addr,      w_addr_nx;
  logic [DATA_WIDTH-1:0] r_wdata,     w_wdata_nx;
  logic [STRB_WIDTH-1:0] r_wstrb,     w_wstrb_nx;

  logic w_aw_hs;
  logic w_w_hs;

  assign w_aw_hs = r_awvalid & m_axil_awready;
  assign w_w_hs  = r_wvalid  & m_axil_wready;

  // State and every output are registered; the comb block below only decides
  // what they become on the next edge.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, whatever the statement order.
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_mem_ready <= 1'b0;
      r_mem_err   <= 1'b0;
      r_rdata     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_awvalid   <= w_awvalid_nx;
      r_wvalid    <= w_wvalid_nx;
      r_bready    <= w_bready_nx;
      r_arvalid   <= w_arvalid_nx;
      r_rready    <= w_rready_nx;
      r_aw_done   <= w_aw_done_nx;
      r_w_done    <= w_w_done_nx;
      r_mem_ready <= w_mem_ready_nx;
      r_mem_err   <= w_mem_err_nx;
      r_rdata     <= w_rdata_nx;
      r_addr      <= w_addr_nx;
      r_wdata     <= w_wdata_nx;
      r_wstrb     <= w_wstrb_nx;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default (hold, or 0 for the ready pulse) before
    // the case statement, so no path can leave one unassigned and infer a latch.
    w_state_nx     = r_state;
    w_awvalid_nx   = r_awvalid;
    w_wvalid_nx    = r_wvalid;
    w_bready_nx    = r_bready;
    w_arvalid_nx   = r_arvalid;
    w_rready_nx    = r_rready;
    w_aw_done_nx   = r_aw_done;
    w_w_done_nx    = r_w_done;
    w_mem_ready_nx = 1'b0;
    w_mem_err_nx   = r_mem_err;
    w_rdata_nx     = r_rdata;
    w_addr_nx      = r_addr;
    w_wdata_nx     = r_wdata;
    w_wstrb_nx     = r_wstrb;

    unique case (r_state)
      ST_IDLE: begin
        if (mem_valid) begin
          // The payload is frozen here and held until the transaction ends.
          w_addr_nx    = mem_addr;
          w_wdata_nx   = mem_wdata;
          w_wstrb_nx   = mem_wstrb;
          w_aw_done_nx = 1'b0;
          w_w_done_nx  = 1'b0;
          if (|mem_wstrb) begin
            w_state_nx   = ST_WR;
            w_awvalid_nx = 1'b1;
            w_wvalid_nx  = 1'b1;
          end else begin
            w_state_nx   = ST_RD_A;
            w_arvalid_nx = 1'b1;
          end
        end
      end

      ST_WR: begin
        // AW and W complete independently; a handshake in this very cycle
        // counts toward "both done" so the fast path loses no cycle.
        if (w_aw_hs) begin
          w_awvalid_nx = 1'b0;
          w_aw_done_nx = 1'b1;
        end
        if (w_w_hs) begin
          w_wvalid_nx = 1'b0;
          w_w_done_nx = 1'b1;
        end
        if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
          w_state_nx  = ST_WR_B;
          w_bready_nx = 1'b1;
        end
      end

      ST_WR_B: begin
        if (m_axil_bvalid && r_bready) begin
          w_mem_err_nx   = (m_axil_bresp != 2'b00);
          w_bready_nx    = 1'b0;
          w_mem_ready_nx = 1'b1;
          w_state_nx     = ST_DONE;
        end
      end

      ST_RD_A: begin
        if (r_arvalid && m_axil_arready) begin
          w_arvalid_nx = 1'b0;
          w_rready_nx  = 1'b1;
          w_state_nx   = ST_RD_R;
        end
      end

      ST_RD_R: begin
        if (m_axil_rvalid && r_rready) begin
          w_rdata_nx     = m_axil_rdata;
          w_mem_err_nx   = (m_axil_rresp != 2'b00);
          w_rready_nx    = 1'b0;
          w_mem_ready_nx = 1'b1;
          w_state_nx     = ST_DONE;
        end
      end

      // mem_valid is ignored here: a CPU that drops valid one cycle after
      // seeing ready must not start a second copy of the same request.
      ST_DONE: w_state_nx = ST_IDLE;

      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign mem_ready      = r_mem_ready;
  assign mem_rdata      = r_rdata;
  assign mem_err        = r_mem_err;
  assign m_axil_awaddr  = r_addr;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = r_awvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = r_wstrb;
  assign m_axil_wvalid  = r_wvalid;
  assign m_axil_bready  = r_bready;
  assign m_axil_araddr  = r_addr;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = r_arvalid;
  assign m_axil_rready  = r_rready;

endmodule

// File: tb/tb_mem_axil_master.sv
// -----------------------------------------------------------------------------
// tb_mem_axil_master
//
// Directed bench for mem_axil_master. A small AXI-Lite slave with programmable
// per-channel stalls answers each request. A negedge monitor compares the DUT
// every cycle against the request that is currently outstanding: payload on the
// address/data channels, ordering of the handshakes, valid-hold rules and the
// completion data. Hand-computed latencies and literal values pin the model.
// -----------------------------------------------------------------------------
module tb_mem_axil_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int LIM = 200;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;
  logic [AW-1:0] m_axil_awaddr;
  logic [2:0]    m_axil_awprot;
  logic          m_axil_awvalid;
  logic          m_axil_awready;
  logic [DW-1:0] m_axil_wdata;
  logic [SW-1:0] m_axil_wstrb;
  logic          m_axil_wvalid;
  logic          m_axil_wready;
  logic [1:0]    m_axil_bresp;
  logic          m_axil_bvalid;
  logic          m_axil_bready;
  logic [AW-1:0] m_axil_araddr;
  logic [2:0]    m_axil_arprot;
  logic          m_axil_arvalid;
  logic          m_axil_arready;
  logic [DW-1:0] m_axil_rdata;
  logic [1:0]    m_axil_rresp;
  logic          m_axil_rvalid;
  logic          m_axil_rready;

  always #5 clk_i = ~clk_i;

  mem_axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .mem_valid      (mem_valid),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .mem_err        (mem_err),
    .m_axil_awaddr  (m_axil_awaddr),
    .m_axil_awprot  (m_axil_awprot),
    .m_axil_awvalid (m_axil_awvalid),
    .m_axil_awready (m_axil_awready),
    .m_axil_wdata   (m_axil_wdata),
    .m_axil_wstrb   (m_axil_wstrb),
    .m_axil_wvalid  (m_axil_wvalid),
    .m_axil_wready  (m_axil_wready),
    .m_axil_bresp   (m_axil_bresp),
    .m_axil_bvalid  (m_axil_bvalid),
    .m_axil_bready  (m_axil_bready),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arprot  (m_axil_arprot),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_arready (m_axil_arready),
    .m_axil_rdata   (m_axil_rdata),
    .m_axil_rresp   (m_axil_rresp),
    .m_axil_rvalid  (m_axil_rvalid),
    .m_axil_rready  (m_axil_rready)
  );

  // ---------------------------------------------------------------- scoring
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------- request model (CPU side)
  int            issued = 0;      // requests handed to the DUT
  logic          cur_wr;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic [SW-1:0] cur_wstrb;
  logic [DW-1:0] cur_rdata;       // data the slave will return for a read
  logic          exp_err;         // response was not OKAY
  int            last_lat;

  // ------------------------------------------------- monitor-owned state
  int            done_cnt = 0;    // completions seen on mem_ready
  int            seen_issued = 0;
  logic [DW-1:0] last_rdata = '0; // what mem_rdata must show on completion
  int aw_hs, w_hs, ar_hs, aw_hi, w_hi, aw_stall, w_stall, ar_stall;
  logic prev_aw_pend, prev_w_pend, prev_ar_pend;
  logic [AW-1:0] seen_awaddr;
  logic [DW-1:0] seen_wdata, seen_rdata;
  logic [SW-1:0] seen_wstrb;
  logic          seen_err;

  always @(negedge clk_i) begin
    logic active;
    if (rst_i) begin
      // Reset abandons whatever was in flight and clears mem_rdata.
      done_cnt     = issued;
      last_rdata   = '0;
      prev_aw_pend = 1'b0;
      prev_w_pend  = 1'b0;
      prev_ar_pend = 1'b0;
    end else begin
      if (seen_issued != issued) begin
        seen_issued = issued;
        aw_hs = 0; w_hs = 0; ar_hs = 0;
        aw_hi = 0; w_hi = 0;
        aw_stall = 0; w_stall = 0; ar_stall = 0;
      end
      active = (done_cnt != issued);

      check("aw_ar_overlap", m_axil_awvalid & m_axil_arvalid, 0);
      check("prot", {m_axil_awprot, m_axil_arprot}, 0);
      check("awvalid_held", prev_aw_pend & ~m_axil_awvalid, 0);
      check("wvalid_held",  prev_w_pend  & ~m_axil_wvalid,  0);
      check("arvalid_held", prev_ar_pend & ~m_axil_arvalid, 0);

      if (m_axil_awvalid | m_axil_wvalid | m_axil_arvalid | m_axil_bready | m_axil_rready)
        check("axi_busy_without_request", active, 1);
      if (m_axil_awvalid | m_axil_wvalid | m_axil_bready)
        check("write_channel_on_read", cur_wr, 1);
      if (m_axil_arvalid | m_axil_rready)
        check("read_channel_on_write", cur_wr, 0);

      if (m_axil_awvalid) begin
        check("awaddr", m_axil_awaddr, cur_addr);
        seen_awaddr = m_axil_awaddr;
      end
      if (m_axil_wvalid) begin
        check("wdata", m_axil_wdata, cur_wdata);
        check("wstrb", m_axil_wstrb, cur_wstrb);
        seen_wdata = m_axil_wdata;
        seen_wstrb = m_axil_wstrb;
      end
      if (m_axil_arvalid) check("araddr", m_axil_araddr, cur_addr);
      if (m_axil_bready)  check("bready_before_aw_w_done", (aw_hs == 1) && (w_hs == 1), 1);
      if (m_axil_rready)  check("rready_before_ar_done", ar_hs, 1);

      if (mem_ready) begin
        check("ready_without_request", active, 1);
        check("mem_err", mem_err, exp_err);
        seen_err = mem_err;
        if (cur_wr) begin
          check("aw_handshakes", aw_hs, 1);
          check("w_handshakes", w_hs, 1);
          check("mem_rdata_held", mem_rdata, last_rdata);
        end else begin
          check("ar_handshakes", ar_hs, 1);
          check("mem_rdata", mem_rdata, cur_rdata);
          last_rdata = cur_rdata;
        end
        seen_rdata = mem_rdata;
        done_cnt++;
      end

      // Handshakes complete on the next rising edge.
      if (m_axil_awvalid) begin aw_hi++; if (m_axil_awready) aw_hs++; else aw_stall++; end
      if (m_axil_wvalid)  begin w_hi++;  if (m_axil_wready)  w_hs++;  else w_stall++;  end
      if (m_axil_arvalid) begin          if (m_axil_arready) ar_hs++; else ar_stall++; end
      prev_aw_pend = m_axil_awvalid & ~m_axil_awready;
      prev_w_pend  = m_axil_wvalid  & ~m_axil_wready;
      prev_ar_pend = m_axil_arvalid & ~m_axil_arready;
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic aw_slave(input int dly);
    int g = 0;
    while (!m_axil_awvalid && g < LIM) begin step(); g++; end
    check("aw_wait_timeout", g >= LIM, 0);
    repeat (dly) step();
    m_axil_awready = 1'b1; step(); m_axil_awready = 1'b0;
  endtask

  task automatic w_slave(input int dly);
    int g = 0;
    while (!m_axil_wvalid && g < LIM) begin step(); g++; end
    check("w_wait_timeout", g >= LIM, 0);
    repeat (dly) step();
    m_axil_wready = 1'b1; step(); m_axil_wready = 1'b0;
  endtask

  task automatic b_slave(input int dly, input logic [1:0] resp);
    int g = 0;
    while (!m_axil_bready && g < LIM) begin step(); g++; end
    check("b_wait_timeout", g >= LIM, 0);
    repeat (dly) step();
    m_axil_bvalid = 1'b1; m_axil_bresp = resp;
    step();
    m_axil_bvalid = 1'b0; m_axil_bresp = 2'b11;
  endtask

  task automatic ar_slave(input int dly);
    int g = 0;
    while (!m_axil_arvalid && g < LIM) begin step(); g++; end
    check("ar_wait_timeout", g >= LIM, 0);
    repeat (dly) step();
    m_axil_arready = 1'b1; step(); m_axil_arready = 1'b0;
  endtask

  task automatic r_slave(input int dly, input logic [1:0] resp, input logic [DW-1:0] data);
    int g = 0;
    while (!m_axil_rready && g < LIM) begin step(); g++; end
    check("r_wait_timeout", g >= LIM, 0);
    repeat (dly) step();
    m_axil_rvalid = 1'b1; m_axil_rresp = resp; m_axil_rdata = data;
    step();
    m_axil_rvalid = 1'b0; m_axil_rresp = 2'b11; m_axil_rdata = 32'hBAD0_BAD0;
  endtask

  // Drive one request; last_lat counts cycles from the sampling edge to the
  // cycle where mem_ready is high. hold keeps mem_valid up that many cycles
  // past mem_ready.
  task automatic cpu_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] wstrb, input int hold);
    int lat;
    step();
    issued++;
    cur_wr = wr; cur_addr = addr; cur_wdata = wdata; cur_wstrb = wstrb;
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    lat = 0;
    do begin step(); lat++; end while (!mem_ready && lat < LIM);
    check("ready_wait_timeout", lat >= LIM, 0);
    repeat (hold) step();
    mem_valid = 1'b0; mem_wstrb = '0;
    @(negedge clk_i); #1;
    check("one_completion", done_cnt, issued);
    last_lat = lat;
  endtask

  task automatic run_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb,
                        input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] resp,
                        input int hold);
    exp_err = (resp != 2'b00);
    fork
      cpu_txn(1'b1, addr, data, strb, hold);
      aw_slave(aw_dly);
      w_slave(w_dly);
      b_slave(b_dly, resp);
    join
  endtask

  task automatic run_rd(input logic [AW-1:0] addr, input int ar_dly, input int r_dly,
                        input logic [1:0] resp, input logic [DW-1:0] data, input int hold);
    exp_err   = (resp != 2'b00);
    cur_rdata = data;
    fork
      cpu_txn(1'b0, addr, 32'h0, 4'h0, hold);
      ar_slave(ar_dly);
      r_slave(r_dly, resp, data);
    join
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valids"}, {m_axil_awvalid, m_axil_wvalid, m_axil_bready,
                             m_axil_arvalid, m_axil_rready, mem_ready}, 0);
    check({tag, "_mem"}, {mem_err, mem_rdata}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst_i = 1'b1;
    mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_arready = 1'b0;
    m_axil_bvalid = 1'b0; m_axil_bresp = 2'b11;
    m_axil_rvalid = 1'b0; m_axil_rresp = 2'b11; m_axil_rdata = 32'hBAD0_BAD0;
    cur_wr = 1'b0; cur_addr = '0; cur_wdata = '0; cur_wstrb = '0; cur_rdata = '0; exp_err = 1'b0;
    repeat (3) step();

    // Reset state.
    check_idle_outputs("reset");
    check("reset_addr",  {m_axil_awaddr, m_axil_araddr}, 0);
    check("reset_wdata", {m_axil_wdata, m_axil_wstrb}, 0);
    rst_i = 1'b0;

    // Full-word write, slave always ready.
    run_wr(32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 0);
    check("wr_latency", last_lat, 3);
    check("wr_awaddr_lit", seen_awaddr, 32'h100);
    check("wr_wdata_lit", seen_wdata, 32'hDEADBEEF);
    check("wr_err_lit", seen_err, 0);

    // Read back with a 5-cycle AR stall.
    run_rd(32'h100, 5, 0, 2'b00, 32'hDEADBEEF, 0);
    check("rd_ar_stall_cycles", ar_stall, 5);
    check("rd_latency", last_lat, 8);
    check("rd_rdata_lit", seen_rdata, 32'hDEADBEEF);
    check("rd_err_lit", seen_err, 0);

    // AW late, W immediate; then the reverse.
    run_wr(32'h204, 32'h12345678, 4'hF, 4, 0, 0, 2'b00, 0);
    check("split_aw_stall", aw_stall, 4);
    check("split_w_cycles", w_hi, 1);
    check("split_latency", last_lat, 7);
    run_wr(32'h208, 32'h87654321, 4'hF, 0, 4, 0, 2'b00, 0);
    check("split2_w_stall", w_stall, 4);
    check("split2_aw_cycles", aw_hi, 1);
    check("split2_latency", last_lat, 7);

    // SLVERR read, then an OKAY write with a delayed B.
    run_rd(32'h300, 0, 0, 2'b10, 32'hCAFEF00D, 0);
    check("err_rd_err_lit", seen_err, 1);
    check("err_rd_latency", last_lat, 3);
    run_wr(32'h304, 32'h55AA55AA, 4'h3, 0, 0, 2, 2'b00, 0);
    check("ok_wr_err_lit", seen_err, 0);
    check("ok_wr_latency", last_lat, 5);
    check("ok_wr_rdata_kept", seen_rdata, 32'hCAFEF00D);

    // Partial strobe with mem_valid held into DONE, then a read right after.
    run_wr(32'h400, 32'hA5A5A5A5, 4'b0010, 0, 0, 0, 2'b00, 1);
    check("partial_wstrb_lit", seen_wstrb, 4'b0010);
    run_rd(32'h400, 0, 1, 2'b00, 32'h0000A500, 0);
    check("b2b_rd_latency", last_lat, 4);

    // Reset while waiting in RD_R with rvalid low.
    step();
    issued++;
    cur_wr = 1'b0; cur_addr = 32'h500; cur_rdata = 32'h0; exp_err = 1'b0;
    mem_valid = 1'b1; mem_addr = 32'h500; mem_wstrb = 4'h0;
    ar_slave(0);
    g = 0;
    while (!m_axil_rready && g < LIM) begin step(); g++; end
    check("midrst_rready_timeout", g >= LIM, 0);
    rst_i = 1'b1; mem_valid = 1'b0;
    step();
    check_idle_outputs("midrst");
    rst_i = 1'b0;
    step();
    check_idle_outputs("midrst_after");
    run_rd(32'h500, 0, 0, 2'b00, 32'h13579BDF, 0);
    check("post_rst_rd_latency", last_lat, 3);
    check("post_rst_rdata_lit", seen_rdata, 32'h13579BDF);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
